// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encoding, wait-state limit and address helper for the Wishbone SRAM target
package wb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} wb_state_e;
  localparam int WAIT_MAX = 15;
  function automatic int adr_lsb(input int dw);
    return $clog2(dw / 8);
  endfunction
endpackage

// File: rtl/wb_sram_target_mem.sv
// wb_sram_target_mem: single-port RAM with 1-cycle synchronous read and per-byte write enables
module wb_sram_target_mem #(
  parameter int DW = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  i_clk,
  input  logic                  i_en,
  input  logic                  i_we,
  input  logic [DW/8-1:0]       i_be,
  input  logic [DEPTH_LOG2-1:0] i_idx,
  input  logic [DW-1:0]         i_wdata,
  output logic [DW-1:0]         o_rdata
);
  logic [DW-1:0] r_mem [1<<DEPTH_LOG2];
  always_ff @(posedge i_clk)
    if (i_en) begin
      if (i_we) begin
        for (int i = 0; i < DW/8; i++)
          if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end else o_rdata <= r_mem[i_idx];
    end
endmodule

// File: rtl/wb_sram_target.sv
// wb_sram_target: Wishbone classic target over a single-port SRAM with wait states,
// byte-lane writes and an error response outside its address window
module wb_sram_target import wb_pkg::*; #(
  parameter int                       WB_ADDR_WIDTH = 32,
  parameter int                       WB_DATA_WIDTH = 32,
  parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADR      = 32'h2800_0000,
  parameter int                       DEPTH_LOG2    = 10,
  parameter int                       WAIT_STATES   = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [WB_ADDR_WIDTH-1:0]   i_adr,
  input  logic [WB_DATA_WIDTH-1:0]   i_dat_w,
  output logic [WB_DATA_WIDTH-1:0]   o_dat_r,
  input  logic                       i_cyc,
  input  logic                       i_stb,
  input  logic                       i_we,
  input  logic [WB_DATA_WIDTH/8-1:0] i_sel,
  output logic                       o_ack,
  output logic                       o_err
);
  localparam int ADR_LSB = adr_lsb(WB_DATA_WIDTH);
  localparam int WS = WAIT_STATES > WAIT_MAX ? WAIT_MAX : WAIT_STATES;
  localparam logic [WB_ADDR_WIDTH-1:0] WIN_MASK = ~((WB_ADDR_WIDTH'(1) << (DEPTH_LOG2 + ADR_LSB)) - 1);
  wb_state_e                    r_state, w_next;
  logic [3:0]                   r_wcnt;
  logic [DEPTH_LOG2-1:0]        r_idx, w_idx;
  logic [WB_DATA_WIDTH-1:0]     r_dat, w_rdata;
  logic [WB_DATA_WIDTH/8-1:0]   r_sel;
  logic                         r_we, r_err;
  logic                         w_in_range, w_accept, w_rd, w_wr;
  assign w_in_range = (i_adr & WIN_MASK) == BASE_ADR;
  assign w_accept   = r_state == IDLE && i_cyc && i_stb;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_accept ? (WS == 0 ? RESP : WAIT) : IDLE;
    else if (r_state == WAIT) w_next = !i_cyc ? IDLE : (r_wcnt == 4'd1 ? RESP : WAIT);
  end
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk)
    if (w_accept) begin
      r_idx  <= i_adr[ADR_LSB +: DEPTH_LOG2];
      r_we   <= i_we;
      r_sel  <= i_sel;
      r_dat  <= i_dat_w;
      r_err  <= !w_in_range;
      r_wcnt <= 4'(WS);
    end else if (r_state == WAIT) r_wcnt <= r_wcnt - 4'd1;
  // With zero wait states the read launches on the accept edge, before the latches settle
  assign w_idx = r_state == IDLE ? i_adr[ADR_LSB +: DEPTH_LOG2] : r_idx;
  assign w_rd  = !i_rst && w_next == RESP &&
                 (r_state == IDLE ? (w_in_range && !i_we) : (!r_err && !r_we));
  assign w_wr  = !i_rst && r_state == RESP && r_we && !r_err && i_cyc;
  wb_sram_target_mem #(.DW(WB_DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_mem (
    .i_clk   (i_clk),
    .i_en    (w_rd || w_wr),
    .i_we    (w_wr),
    .i_be    (r_sel),
    .i_idx   (w_idx),
    .i_wdata (r_dat),
    .o_rdata (w_rdata)
  );
  assign o_ack   = r_state == RESP && !r_err;
  assign o_err   = r_state == RESP && r_err;
  assign o_dat_r = o_ack && !r_we ? w_rdata : '0;
endmodule

// File: tb/tb_wb_sram_target.sv
// tb_wb_sram_target: directed checks of latency, byte lanes, range errors, aborts and reset
module tb_wb_sram_target;
  import wb_pkg::*;
  logic        clk = 0, rst = 1, cyc = 0, stb = 0, we = 0;
  logic [31:0] adr = '0, dw = '0;
  logic [3:0]  sel = '0, ack, err;
  logic [31:0] dr [4];
  int          n_chk = 0, n_fail = 0, lat;
  logic        ka, ke, tl;
  logic [31:0] rd;
  always #5 clk = ~clk;
  wb_sram_target #(.WAIT_STATES(1)) u0 (.i_clk(clk), .i_rst(rst), .i_adr(adr), .i_dat_w(dw), .o_dat_r(dr[0]),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel), .o_ack(ack[0]), .o_err(err[0]));
  wb_sram_target #(.WAIT_STATES(0)) u1 (.i_clk(clk), .i_rst(rst), .i_adr(adr), .i_dat_w(dw), .o_dat_r(dr[1]),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel), .o_ack(ack[1]), .o_err(err[1]));
  wb_sram_target #(.WAIT_STATES(15)) u2 (.i_clk(clk), .i_rst(rst), .i_adr(adr), .i_dat_w(dw), .o_dat_r(dr[2]),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel), .o_ack(ack[2]), .o_err(err[2]));
  wb_sram_target #(.WAIT_STATES(3)) u3 (.i_clk(clk), .i_rst(rst), .i_adr(adr), .i_dat_w(dw), .o_dat_r(dr[3]),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_sel(sel), .o_ack(ack[3]), .o_err(err[3]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Two idle cycles return every instance to IDLE (WAIT aborts on cyc=0, RESP always ends)
  task automatic access(input int n, input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
    cyc = 0; stb = 0;
    tick(); tick();
    adr = a; we = w; dw = d; sel = s; cyc = 1; stb = 1;
    lat = -1; ka = 0; ke = 0; rd = '0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (ack[n] || err[n]) begin lat = k; ka = ack[n]; ke = err[n]; rd = dr[n]; end
    end
    tick();
    tl = ack[n] || err[n];
    cyc = 0; stb = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    tick(); tick(); tick();
    n_chk++; if (ack !== 4'h0) begin n_fail++; $display("FAIL reset_ack got %b want 0000", ack); end
    n_chk++; if (err !== 4'h0) begin n_fail++; $display("FAIL reset_err got %b want 0000", err); end
    n_chk++; if (dr[0] !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", dr[0]); end
    rst = 0;
  endtask
  task automatic test_write_read;
    access(0, 32'h2800_0010, 1, 32'hDEAD_BEEF, 4'hF);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL wr_lat got %0d want 2", lat); end
    n_chk++; if ({ka, ke} !== 2'b10) begin n_fail++; $display("FAIL wr_ackerr got %b want 10", {ka, ke}); end
    n_chk++; if (tl !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width got %b want 0", tl); end
    access(0, 32'h2800_0010, 0, 32'h0, 4'hF);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL rd_lat got %0d want 2", lat); end
    n_chk++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got %h want deadbeef", rd); end
  endtask
  task automatic test_byte_lanes;
    access(0, 32'h2800_0010, 1, 32'h1122_3344, 4'b0101);
    access(0, 32'h2800_0010, 0, 32'h0, 4'hF);
    n_chk++; if (rd !== 32'hDE22_BE44) begin n_fail++; $display("FAIL lanes_data got %h want de22be44", rd); end
    access(0, 32'h2800_0010, 1, 32'hFFFF_FFFF, 4'h0);
    n_chk++; if ({ka, ke} !== 2'b10) begin n_fail++; $display("FAIL sel0_ack got %b want 10", {ka, ke}); end
    access(0, 32'h2800_0010, 0, 32'h0, 4'hF);
    n_chk++; if (rd !== 32'hDE22_BE44) begin n_fail++; $display("FAIL sel0_data got %h want de22be44", rd); end
  endtask
  task automatic test_out_of_range;
    access(0, 32'h2800_0000, 1, 32'hA5A5_A5A5, 4'hF);
    access(0, 32'h2800_1000, 1, 32'h1234_5678, 4'hF);
    n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL oor_lat got %0d want 2", lat); end
    n_chk++; if ({ka, ke} !== 2'b01) begin n_fail++; $display("FAIL oor_ackerr got %b want 01", {ka, ke}); end
    access(0, 32'h2800_1000, 0, 32'h0, 4'hF);
    n_chk++; if ({ke, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL oor_rd got err=%b dat=%h want err=1 dat=0", ke, rd); end
    access(0, 32'h2800_0000, 0, 32'h0, 4'hF);
    n_chk++; if (rd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL oor_word0 got %h want a5a5a5a5", rd); end
  endtask
  task automatic test_latency;
    access(1, 32'h2800_0004, 1, 32'h0102_0304, 4'hF);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL ws0_lat got %0d want 1", lat); end
    access(1, 32'h2800_0004, 0, 32'h0, 4'hF);
    n_chk++; if (rd !== 32'h0102_0304) begin n_fail++; $display("FAIL ws0_data got %h want 01020304", rd); end
    access(2, 32'h2800_0008, 1, 32'h5566_7788, 4'hF);
    n_chk++; if (lat !== 16) begin n_fail++; $display("FAIL ws15_lat got %0d want 16", lat); end
    access(2, 32'h2800_0008, 0, 32'h0, 4'hF);
    n_chk++; if ({lat, rd} !== {32'd16, 32'h5566_7788}) begin n_fail++; $display("FAIL ws15_rd got lat=%0d dat=%h want 16 55667788", lat, rd); end
  endtask
  task automatic test_back_to_back(input int n, input int per);
    int t[3];
    int c;
    t = '{-100, -100, -100};
    c = 0;
    cyc = 0; stb = 0;
    tick(); tick();
    adr = 32'h2800_0010; we = 0; sel = 4'hF; cyc = 1; stb = 1;
    for (int k = 1; k <= 80 && c < 3; k++) begin
      tick();
      if (ack[n]) begin t[c] = k; c++; end
    end
    cyc = 0; stb = 0;
    n_chk++; if (t[0] !== per - 1) begin n_fail++; $display("FAIL b2b%0d_first got %0d want %0d", n, t[0], per - 1); end
    n_chk++; if (t[1] - t[0] !== per) begin n_fail++; $display("FAIL b2b%0d_gap1 got %0d want %0d", n, t[1] - t[0], per); end
    n_chk++; if (t[2] - t[1] !== per) begin n_fail++; $display("FAIL b2b%0d_gap2 got %0d want %0d", n, t[2] - t[1], per); end
  endtask
  task automatic test_abort;
    logic seen;
    access(3, 32'h2800_0020, 1, 32'h0BAD_F00D, 4'hF);
    n_chk++; if (lat !== 4) begin n_fail++; $display("FAIL ws3_lat got %0d want 4", lat); end
    cyc = 0; stb = 0;
    tick(); tick();
    adr = 32'h2800_0020; we = 1; dw = 32'hFFFF_FFFF; sel = 4'hF; cyc = 1; stb = 1;
    tick(); tick();
    cyc = 0; stb = 0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin tick(); seen |= ack[3] | err[3]; end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_resp got %b want 0", seen); end
    access(3, 32'h2800_0020, 0, 32'h0, 4'hF);
    n_chk++; if ({lat, ka} !== {32'd4, 1'b1}) begin n_fail++; $display("FAIL abort_next got lat=%0d ack=%b want 4 1", lat, ka); end
    n_chk++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL abort_data got %h want 0badf00d", rd); end
  endtask
  task automatic test_reset_mid_access;
    logic got;
    access(0, 32'h2800_0040, 1, 32'hCAFE_F00D, 4'hF);
    cyc = 0; stb = 0;
    tick(); tick();
    adr = 32'h2800_0040; we = 1; dw = 32'h0; sel = 4'hF; cyc = 1; stb = 1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin tick(); got = ack[0]; end
    n_chk++; if (got !== 1'b1) begin n_fail++; $display("FAIL rstmid_resp got %b want 1", got); end
    rst = 1;
    tick();
    n_chk++; if ({ack[0], err[0], dr[0]} !== 34'h0) begin n_fail++; $display("FAIL rstmid_out got ack=%b err=%b dat=%h want 0 0 0", ack[0], err[0], dr[0]); end
    n_chk++; if (u0.r_state !== IDLE) begin n_fail++; $display("FAIL rstmid_state got %0d want 0", u0.r_state); end
    rst = 0; cyc = 0; stb = 0;
    access(0, 32'h2800_0040, 0, 32'h0, 4'hF);
    n_chk++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rstmid_data got %h want cafef00d", rd); end
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_latency();
    test_back_to_back(1, 2);
    test_back_to_back(2, 17);
    test_abort();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
